time_set_entry: RTL and testbench
=================================

Name: time_set_entry

Overview:
- Keypad-driven time editor: the writer that feeds the clock/calendar counter block, whose display side turns binary HOUR/MIN/SEC into ASCII digits.
- Takes ASCII keystrokes into a six-digit HH MM SS edit buffer. Validates the entry against the active time format.
- Emits binary hour/minute/second/meridian with a one-cycle LOAD strobe for the counter to capture.
- Drives the buffer as ASCII digits so the LCD path can show the edit in progress.

Parameters:
AM_CODE, 8'h41, meridian code for AM ('A')
PM_CODE, 8'h42, meridian code for PM ('B')
KEY_BACK, 8'h2A, backspace key ('*')
KEY_ENTER, 8'h23, commit key ('#')
KEY_MER, 8'h4D, meridian toggle key ('M')

Ports:
CLK  in  1  system clock
RESETN  in  1  reset; synchronous, active-low
START  in  1  one-cycle request to enter edit mode
CANCEL  in  1  abort edit without loading
KEY_VALID  in  1  one-cycle keystroke strobe
KEY_CODE  in  8  ASCII key code, sampled when KEY_VALID=1
TIME_FORMAT  in  1  0 = 24h, 1 = 12h
CUR_HOUR, CUR_MIN, CUR_SEC  in  7 each  current running time, used as preload
CUR_MERIDIAN  in  8  current meridian code
SET_HOUR, SET_MIN, SET_SEC  out  7 each  binary time to load
SET_MERIDIAN  out  8  meridian to load
LOAD  out  1  one-cycle load strobe
ERROR  out  1  one-cycle invalid-entry strobe
EDITING  out  1  high in EDIT/CHECK/ERR
CURSOR  out  3  edit position, 0..6 (0 = H10, 5 = S1, 6 = complete)
out_E_H10, out_E_H1, out_E_M10, out_E_M1, out_E_S10, out_E_S1  out  8 each  buffer digits as ASCII (0x30–0x39)

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE
  - all buffer digits 0, so out_E_* = 8'h30
  - CURSOR = 0
  - LOAD, ERROR, EDITING = 0
  - SET_HOUR, SET_MIN, SET_SEC = 0
  - SET_MERIDIAN = AM_CODE
- Reset asserted mid-edit returns to these values at the next edge; no LOAD is issued.
- IDLE:
  - START → EDIT.
  - Buffer preloaded from CUR_* via binary-to-BCD (tens = v/10, ones = v%10). Inputs above 99 saturate to 9,9.
  - Edit meridian ← CUR_MERIDIAN; CURSOR ← 0.
  - KEY_VALID is ignored in IDLE.
- EDIT (per KEY_VALID cycle; CANCEL has priority over any key in the same cycle):
  - Digit 0x30–0x39: buffer[CURSOR] ← KEY_CODE − 0x30, then CURSOR+1. At CURSOR = 6 the key is ignored.
  - KEY_BACK: CURSOR−1 and the digit is retained. At CURSOR = 0 the key is ignored.
  - KEY_MER: toggles the edit meridian AM↔PM only when TIME_FORMAT = 1; otherwise ignored.
  - KEY_ENTER: → CHECK, accepted at any CURSOR value.
  - Any other code is ignored.
  - CANCEL → IDLE; buffer retained, SET_* unchanged.
  - START is ignored outside IDLE.
- CHECK (exactly 1 cycle):
  - h = H10·10 + H1, m = M10·10 + M1, s = S10·10 + S1, computed in 7-bit arithmetic.
  - Valid when h ≤ 23 (TIME_FORMAT = 0) or h ≤ 11 (TIME_FORMAT = 1), m ≤ 59, and s ≤ 59.
  - Valid → LOAD; invalid → ERR.
  - KEY_VALID and CANCEL are ignored in CHECK.
- LOAD state:
  - SET_* ← h, m, s and edit meridian.
  - LOAD = 1 for this single cycle → IDLE.
  - SET_* hold until the next LOAD.
  - Latency: '#' sampled at edge N → CHECK at N+1 → LOAD high during cycle after edge N+2.
- ERR:
  - ERROR = 1 for one cycle → EDIT with CURSOR = 0; buffer retained.
  - Keys are ignored in ERR.
- If TIME_FORMAT changes during EDIT, CHECK uses the value sampled in the CHECK cycle.
- SET_MERIDIAN is loaded even when TIME_FORMAT = 0; the downstream counter ignores it in that mode.

Test Plan:
- Reset, START with CUR = 13:45:07 → out_E_* = "134507" (0x31,0x33,0x34,0x35,0x30,0x37), CURSOR = 0, EDITING = 1.
- 24h: keys 2,1,0,5,3,0,'#' → LOAD high exactly 2 cycles after the '#' strobe; SET = 21/5/30, EDITING = 0 afterwards.
- 24h entry 24:00:00 then '#' → ERROR one cycle, no LOAD, CURSOR = 0, buffer still "240000". Then backspace at CURSOR = 0 is ignored.
- 12h: preload AM, keys 1,1,5,9,5,9,'M','#' → SET = 11/59/59, SET_MERIDIAN = 8'h42. In 24h mode 'M' is ignored and meridian stays 8'h41.
- Backspace/saturation: after 6 digits a 7th digit leaves CURSOR = 6; '*' gives CURSOR = 5 and the next digit overwrites S1 only.
- CANCEL and KEY_VALID('#') in the same cycle → IDLE, no LOAD or ERROR. RESETN low mid-edit → all outputs at reset values next cycle.

Source files
------------

// File: rtl/time_set_entry_if.sv
// -----------------------------------------------------------------------------
// time_set_entry_if
// Keypad-to-editor and editor-to-counter signal bundle for time_set_entry.
//   KEY_VALID    one-cycle keystroke strobe (keypad -> editor)
//   KEY_CODE     ASCII key code, meaningful while KEY_VALID = 1
//   LOAD         one-cycle strobe telling the counter to capture SET_*
//   SET_HOUR     binary hour to load
//   SET_MIN      binary minute to load
//   SET_SEC      binary second to load
//   SET_MERIDIAN meridian code to load
// The master modport is the keypad/counter side; slave is the editor.
// -----------------------------------------------------------------------------
interface time_set_entry_if;
  logic       KEY_VALID;
  logic [7:0] KEY_CODE;
  logic       LOAD;
  logic [6:0] SET_HOUR;
  logic [6:0] SET_MIN;
  logic [6:0] SET_SEC;
  logic [7:0] SET_MERIDIAN;

  modport master (
    output KEY_VALID, KEY_CODE,
    input  LOAD, SET_HOUR, SET_MIN, SET_SEC, SET_MERIDIAN
  );

  modport slave (
    input  KEY_VALID, KEY_CODE,
    output LOAD, SET_HOUR, SET_MIN, SET_SEC, SET_MERIDIAN
  );
endinterface

// File: rtl/time_set_entry.sv
// -----------------------------------------------------------------------------
// time_set_entry
// Keypad-driven HH MM SS editor feeding the clock/calendar counter.
//   CLK, RESETN        clock; synchronous active-low reset
//   START              enter edit mode, preloading the buffer from CUR_*
//   CANCEL             leave edit mode without loading
//   TIME_FORMAT        0 = 24h, 1 = 12h (limits the hour, enables 'M')
//   CUR_HOUR/MIN/SEC   running time in binary, used as the preload
//   CUR_MERIDIAN       running meridian code, used as the preload
//   bus                keystrokes in; SET_* and LOAD out to the counter
//   ERROR              one-cycle strobe for a rejected entry
//   EDITING            high while editing, checking or reporting an error
//   CURSOR             next digit to be written (0 = H10 .. 5 = S1, 6 = full)
//   out_E_*            edit buffer as ASCII digits for the LCD path
// LOAD, ERROR and SET_* are registered from the LOAD/ERR states, so they
// appear in the cycle after those states: '#' sampled at edge N gives
// CHECK after N, LOAD state after N+1 and the LOAD strobe after N+2.
// -----------------------------------------------------------------------------
module time_set_entry #(
  parameter logic [7:0] AM_CODE   = 8'h41,
  parameter logic [7:0] PM_CODE   = 8'h42,
  parameter logic [7:0] KEY_BACK  = 8'h2A,
  parameter logic [7:0] KEY_ENTER = 8'h23,
  parameter logic [7:0] KEY_MER   = 8'h4D
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              START,
  input  logic              CANCEL,
  input  logic              TIME_FORMAT,
  input  logic [6:0]        CUR_HOUR,
  input  logic [6:0]        CUR_MIN,
  input  logic [6:0]        CUR_SEC,
  input  logic [7:0]        CUR_MERIDIAN,
  time_set_entry_if.slave   bus,
  output logic              ERROR,
  output logic              EDITING,
  output logic [2:0]        CURSOR,
  output logic [7:0]        out_E_H10,
  output logic [7:0]        out_E_H1,
  output logic [7:0]        out_E_M10,
  output logic [7:0]        out_E_M1,
  output logic [7:0]        out_E_S10,
  output logic [7:0]        out_E_S1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_CHECK,
    S_LOAD,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] dig_q [6];
  logic [3:0] dig_d [6];
  logic [2:0] cursor_q, cursor_d;
  logic [7:0] mer_q, mer_d;
  logic       load_q, load_d;
  logic       error_q, error_d;
  logic       editing_q, editing_d;
  logic [6:0] set_hour_q, set_hour_d;
  logic [6:0] set_min_q, set_min_d;
  logic [6:0] set_sec_q, set_sec_d;
  logic [7:0] set_mer_q, set_mer_d;

  logic [6:0] hour_val, min_val, sec_val;
  logic       entry_valid;
  logic       key_is_digit;

  // Binary to two BCD digits {tens, ones}; anything above 99 shows as 99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    if (v > 7'd99) return 8'h99;
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign hour_val = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign min_val  = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
  assign sec_val  = 7'(dig_q[4]) * 7'd10 + 7'(dig_q[5]);

  // TIME_FORMAT is taken live here, so a mode change made while editing is
  // honoured by whatever value is present in the CHECK cycle.
  assign entry_valid = (hour_val <= (TIME_FORMAT ? 7'd11 : 7'd23)) &&
                       (min_val  <= 7'd59) &&
                       (sec_val  <= 7'd59);

  assign key_is_digit = (bus.KEY_CODE >= 8'h30) && (bus.KEY_CODE <= 8'h39);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d    = state_q;
    dig_d      = dig_q;
    cursor_d   = cursor_q;
    mer_d      = mer_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    set_mer_d  = set_mer_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d            = S_EDIT;
          {dig_d[0], dig_d[1]} = to_bcd(CUR_HOUR);
          {dig_d[2], dig_d[3]} = to_bcd(CUR_MIN);
          {dig_d[4], dig_d[5]} = to_bcd(CUR_SEC);
          cursor_d           = 3'd0;
          mer_d              = CUR_MERIDIAN;
        end
      end

      S_EDIT: begin
        // CANCEL wins over a keystroke arriving in the same cycle.
        if (CANCEL) begin
          state_d = S_IDLE;
        end else if (bus.KEY_VALID) begin
          if (key_is_digit) begin
            if (cursor_q != 3'd6) begin
              dig_d[cursor_q] = bus.KEY_CODE[3:0];
              cursor_d        = cursor_q + 3'd1;
            end
          end else if (bus.KEY_CODE == KEY_BACK) begin
            // Backspace only moves the cursor; the digit under it stays.
            if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
          end else if (bus.KEY_CODE == KEY_MER) begin
            // Anything that is not AM toggles to AM, so an odd preload
            // code still lands on a legal meridian.
            if (TIME_FORMAT) mer_d = (mer_q == AM_CODE) ? PM_CODE : AM_CODE;
          end else if (bus.KEY_CODE == KEY_ENTER) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (entry_valid) begin
          state_d = S_LOAD;
        end else begin
          state_d  = S_ERR;
          cursor_d = 3'd0;
        end
      end

      S_LOAD: begin
        state_d    = S_IDLE;
        set_hour_d = hour_val;
        set_min_d  = min_val;
        set_sec_d  = sec_val;
        set_mer_d  = mer_q;
      end

      S_ERR: begin
        state_d = S_EDIT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d    = (state_q == S_LOAD);
    error_d   = (state_q == S_ERR);
    editing_d = (state_d == S_EDIT) || (state_d == S_CHECK) || (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (!RESETN) begin
      state_q    <= S_IDLE;
      // NOTE: the digit buffer is reset too, because it is visible on the
      // display outputs straight out of reset.
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
      cursor_q   <= 3'd0;
      mer_q      <= AM_CODE;
      load_q     <= 1'b0;
      error_q    <= 1'b0;
      editing_q  <= 1'b0;
      set_hour_q <= 7'd0;
      set_min_q  <= 7'd0;
      set_sec_q  <= 7'd0;
      set_mer_q  <= AM_CODE;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      cursor_q   <= cursor_d;
      mer_q      <= mer_d;
      load_q     <= load_d;
      error_q    <= error_d;
      editing_q  <= editing_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      set_mer_q  <= set_mer_d;
    end
  end

  assign bus.LOAD         = load_q;
  assign bus.SET_HOUR     = set_hour_q;
  assign bus.SET_MIN      = set_min_q;
  assign bus.SET_SEC      = set_sec_q;
  assign bus.SET_MERIDIAN = set_mer_q;
  assign ERROR            = error_q;
  assign EDITING          = editing_q;
  assign CURSOR           = cursor_q;
  assign out_E_H10        = {4'h3, dig_q[0]};
  assign out_E_H1         = {4'h3, dig_q[1]};
  assign out_E_M10        = {4'h3, dig_q[2]};
  assign out_E_M1         = {4'h3, dig_q[3]};
  assign out_E_S10        = {4'h3, dig_q[4]};
  assign out_E_S1         = {4'h3, dig_q[5]};

endmodule

// File: tb/tb_time_set_entry.sv
// -----------------------------------------------------------------------------
// tb_time_set_entry
// Self-checking bench for time_set_entry. A reference model of the editor
// (digit array, cursor, meridian, edit flag) is updated as keys are issued;
// each '#' pushes the expected LOAD or ERROR (with its due cycle) into a
// queue that an independent monitor drains whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_time_set_entry;

  localparam logic [7:0] AM    = 8'h41;
  localparam logic [7:0] PM    = 8'h42;
  localparam logic [7:0] BACK  = 8'h2A;
  localparam logic [7:0] ENTER = 8'h23;
  localparam logic [7:0] MER   = 8'h4D;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       START;
  logic       CANCEL;
  logic       TIME_FORMAT;
  logic [6:0] CUR_HOUR, CUR_MIN, CUR_SEC;
  logic [7:0] CUR_MERIDIAN;
  logic       ERROR, EDITING;
  logic [2:0] CURSOR;
  logic [7:0] out_E_H10, out_E_H1, out_E_M10, out_E_M1, out_E_S10, out_E_S1;

  time_set_entry_if bus ();

  time_set_entry dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .START        (START),
    .CANCEL       (CANCEL),
    .TIME_FORMAT  (TIME_FORMAT),
    .CUR_HOUR     (CUR_HOUR),
    .CUR_MIN      (CUR_MIN),
    .CUR_SEC      (CUR_SEC),
    .CUR_MERIDIAN (CUR_MERIDIAN),
    .bus          (bus.slave),
    .ERROR        (ERROR),
    .EDITING      (EDITING),
    .CURSOR       (CURSOR),
    .out_E_H10    (out_E_H10),
    .out_E_H1     (out_E_H1),
    .out_E_M10    (out_E_M10),
    .out_E_M1     (out_E_M1),
    .out_E_S10    (out_E_S10),
    .out_E_S1     (out_E_S1)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_load;
    int         h, m, s;
    logic [7:0] mer;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  int         m_dig[6];
  int         m_cur;
  logic [7:0] m_mer;
  bit         m_edit;
  int         m_sh, m_sm, m_ss;
  logic [7:0] m_smer;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every LOAD/ERROR cycle must match the head of the queue.
  always @(negedge CLK) begin
    if (bus.LOAD === 1'b1 || ERROR === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {bus.LOAD, ERROR}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {bus.LOAD, ERROR}, e.is_load ? 2'b10 : 2'b01);
        check("strobe_cycle", cyc, e.at);
        if (e.is_load) begin
          check("set_hour", bus.SET_HOUR, e.h);
          check("set_min", bus.SET_MIN, e.m);
          check("set_sec", bus.SET_SEC, e.s);
          check("set_meridian", bus.SET_MERIDIAN, e.mer);
        end else begin
          check("error_cursor", CURSOR, 0);
        end
      end
    end
  end

  task automatic check_view(input string tag);
    check({tag, "_buf"}, {out_E_H10, out_E_H1, out_E_M10, out_E_M1, out_E_S10, out_E_S1},
          {8'(8'h30 + m_dig[0]), 8'(8'h30 + m_dig[1]), 8'(8'h30 + m_dig[2]),
           8'(8'h30 + m_dig[3]), 8'(8'h30 + m_dig[4]), 8'(8'h30 + m_dig[5])});
    check({tag, "_cursor"}, CURSOR, m_cur);
    check({tag, "_editing"}, EDITING, m_edit);
    check({tag, "_set"}, {bus.SET_HOUR, bus.SET_MIN, bus.SET_SEC, bus.SET_MERIDIAN},
          {7'(m_sh), 7'(m_sm), 7'(m_ss), m_smer});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_dig[i] = 0;
    m_cur = 0; m_mer = AM; m_edit = 0;
    m_sh = 0; m_sm = 0; m_ss = 0; m_smer = AM;
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    @(negedge CLK);
    model_reset();
    check("reset_load", bus.LOAD, 1'b0);
    check("reset_error", ERROR, 1'b0);
    check_view("reset");
    RESETN = 1'b1;
  endtask

  task automatic start_session(input int h, input int m, input int s, input logic [7:0] mer);
    CUR_HOUR = 7'(h); CUR_MIN = 7'(m); CUR_SEC = 7'(s); CUR_MERIDIAN = mer;
    START = 1'b1;
    if (!m_edit) begin
      m_dig[0] = (h > 99) ? 9 : h / 10;  m_dig[1] = (h > 99) ? 9 : h % 10;
      m_dig[2] = (m > 99) ? 9 : m / 10;  m_dig[3] = (m > 99) ? 9 : m % 10;
      m_dig[4] = (s > 99) ? 9 : s / 10;  m_dig[5] = (s > 99) ? 9 : s % 10;
      m_cur = 0; m_mer = mer; m_edit = 1;
    end
    @(negedge CLK);
    START = 1'b0;
    check_view("start");
  endtask

  // Issue one keystroke (optionally with CANCEL) and update the model.
  task automatic press(input logic [7:0] code, input bit cancel);
    int  k;
    bit  wait_result;
    k = cyc;
    wait_result = 0;
    bus.KEY_VALID = 1'b1; bus.KEY_CODE = code; CANCEL = cancel;
    if (m_edit) begin
      if (cancel) begin
        m_edit = 0;
      end else if (code >= 8'h30 && code <= 8'h39) begin
        if (m_cur < 6) begin m_dig[m_cur] = int'(code) - 'h30; m_cur++; end
      end else if (code == BACK) begin
        if (m_cur > 0) m_cur--;
      end else if (code == MER) begin
        if (TIME_FORMAT) m_mer = (m_mer == AM) ? PM : AM;
      end else if (code == ENTER) begin
        exp_t e;
        e.h = m_dig[0] * 10 + m_dig[1];
        e.m = m_dig[2] * 10 + m_dig[3];
        e.s = m_dig[4] * 10 + m_dig[5];
        e.mer = m_mer;
        e.at = k + 3;
        e.is_load = (e.h <= (TIME_FORMAT ? 11 : 23)) && (e.m <= 59) && (e.s <= 59);
        if (e.is_load) begin
          m_edit = 0; m_sh = e.h; m_sm = e.m; m_ss = e.s; m_smer = e.mer;
        end else begin
          m_cur = 0;
        end
        exp_q.push_back(e);
        wait_result = 1;
      end
    end
    @(negedge CLK);
    bus.KEY_VALID = 1'b0; CANCEL = 1'b0;
    if (wait_result) repeat (4) @(negedge CLK);
    check_view("key");
  endtask

  task automatic keys(input string str);
    for (int i = 0; i < str.len(); i++) press(str[i], 1'b0);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return 8'(8'h30 + $urandom_range(0, 5));
    if (r < 55) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 67) return BACK;
    if (r < 77) return MER;
    if (r < 85) return ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h20;
    return ENTER;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESETN = 1'b0; START = 1'b0; CANCEL = 1'b0; TIME_FORMAT = 1'b0;
    CUR_HOUR = '0; CUR_MIN = '0; CUR_SEC = '0; CUR_MERIDIAN = AM;
    bus.KEY_VALID = 1'b0; bus.KEY_CODE = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    apply_reset();

    // Preload 13:45:07.
    start_session(13, 45, 7, AM);
    check("preload_ascii", {out_E_H10, out_E_H1, out_E_M10, out_E_M1, out_E_S10, out_E_S1},
          48'h31_33_34_35_30_37);

    // 24h valid entry 21:05:30.
    keys("210530#");
    check("load_21_05_30", {bus.SET_HOUR, bus.SET_MIN, bus.SET_SEC}, {7'd21, 7'd5, 7'd30});

    // 24h invalid 24:00:00, then backspace at cursor 0.
    start_session(1, 2, 3, AM);
    keys("240000#");
    check("err_buffer", {out_E_H10, out_E_H1, out_E_M10, out_E_M1, out_E_S10, out_E_S1},
          48'h32_34_30_30_30_30);
    press(BACK, 1'b0);
    press(8'h00, 1'b1);

    // 12h entry with meridian toggle.
    TIME_FORMAT = 1'b1;
    start_session(3, 0, 0, AM);
    keys("115959M#");
    check("load_12h_pm", bus.SET_MERIDIAN, 8'h42);

    // 24h: 'M' ignored.
    TIME_FORMAT = 1'b0;
    start_session(3, 0, 0, AM);
    keys("100000M#");
    check("load_24h_am", bus.SET_MERIDIAN, 8'h41);

    // Cursor saturation and backspace overwrite of S1 only.
    start_session(8, 8, 8, AM);
    keys("1234567*8");
    press(8'h00, 1'b1);

    // CANCEL together with '#'.
    start_session(9, 9, 9, PM);
    press(ENTER, 1'b1);

    // Reset in the middle of an edit.
    start_session(11, 22, 33, PM);
    keys("12");
    apply_reset();

    // Randomized sessions.
    for (int sess = 0; sess < 60; sess++) begin
      TIME_FORMAT = 1'($urandom_range(0, 1));
      start_session($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
                    ($urandom_range(0, 1) != 0) ? PM : AM);
      for (int i = 0; i < 14 && m_edit; i++) press(rand_key(), $urandom_range(0, 29) == 0);
      if (m_edit) press(8'h00, 1'b1);
      press(rand_key(), 1'b0);
    end

    repeat (4) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
